// File: rtl/arb_ingress_queue.sv
// Per-client ingress FIFOs feeding a WRR arbiter, muxing the granted head onto one stream.
// Optional packet lock (o_lock / pkt_active) is built when ARB_INGRESS_LOCK_EN is defined.
module arb_ingress_queue #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            s_valid,
  output logic [NUM_CLIENTS-1:0]            s_ready,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CLIENTS-1:0]            s_last,
  output logic [NUM_CLIENTS-1:0]            o_req,
  output logic [NUM_CLIENTS-1:0]            o_lock,
  input  logic [NUM_CLIENTS-1:0]            i_gnt,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_last,
  output logic [$clog2(NUM_CLIENTS)-1:0]    m_src,
  output logic                              o_gnt_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_CLIENTS);

  logic [AW:0]           wr_ptr    [NUM_CLIENTS];
  logic [AW:0]           rd_ptr    [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] mem_data  [NUM_CLIENTS][FIFO_DEPTH];
  logic                  mem_last  [NUM_CLIENTS][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head_data [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] full;
  logic [NUM_CLIENTS-1:0] empty;
  logic [NUM_CLIENTS-1:0] push;
  logic [NUM_CLIENTS-1:0] pop;
  logic [NUM_CLIENTS-1:0] head_last;

  logic          gnt_any;
  logic          gnt_multi;
  logic          gnt_onehot;
  logic [SW-1:0] gnt_idx;
  logic          gnt_err;

  // Full when the low bits match but the wrap bits differ; push never bypasses a full FIFO.
  always_comb begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      empty[k]     = (wr_ptr[k] == rd_ptr[k]);
      full[k]      = (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]) && (wr_ptr[k][AW] != rd_ptr[k][AW]);
      head_data[k] = mem_data[k][rd_ptr[k][AW-1:0]];
      head_last[k] = mem_last[k][rd_ptr[k][AW-1:0]];
      push[k]      = s_valid[k] && !full[k];
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (i_gnt[k]) gnt_idx = SW'(k);
    end
    gnt_any    = |i_gnt;
    gnt_multi  = (i_gnt & (i_gnt - NUM_CLIENTS'(1))) != '0;
    gnt_onehot = gnt_any && !gnt_multi;
  end

  always_comb begin
    m_valid = gnt_onehot && !empty[gnt_idx];
    m_data  = m_valid ? head_data[gnt_idx] : '0;
    m_last  = m_valid ? head_last[gnt_idx] : 1'b0;
    m_src   = m_valid ? gnt_idx : '0;
    pop     = {NUM_CLIENTS{m_valid && m_ready}} & i_gnt;
  end

  assign s_ready   = ~full;
  assign o_req     = ~empty;
  assign o_gnt_err = gnt_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      gnt_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
      end
      if (gnt_multi) gnt_err <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only observable through non-empty pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (push[k]) begin
        mem_data[k][wr_ptr[k][AW-1:0]] <= s_data[k*DATA_WIDTH +: DATA_WIDTH];
        mem_last[k][wr_ptr[k][AW-1:0]] <= s_last[k];
      end
    end
  end

`ifdef ARB_INGRESS_LOCK_EN
  logic [NUM_CLIENTS-1:0] pkt_active;

  // Stays set across an empty FIFO so a stalled packet keeps its claim on the arbiter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_active <= '0;
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        if (pop[k]) pkt_active[k] <= !head_last[k];
      end
    end
  end

  assign o_lock = pkt_active | (~empty & ~head_last);
`else
  assign o_lock = '0;
`endif

endmodule

// File: tb/tb_arb_ingress_queue.sv
// Randomized bench for arb_ingress_queue against a queue-based reference model;
// the bench plays the arbiter, including multi-bit grants and mid-traffic resets.
module tb_arb_ingress_queue;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     s_valid;
  logic [NC-1:0]     s_ready;
  logic [NC*DW-1:0]  s_data;
  logic [NC-1:0]     s_last;
  logic [NC-1:0]     o_req;
  logic [NC-1:0]     o_lock;
  logic [NC-1:0]     i_gnt;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic [SW-1:0]     m_src;
  logic              o_gnt_err;

  arb_ingress_queue #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .o_req(o_req), .o_lock(o_lock), .i_gnt(i_gnt),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .o_gnt_err(o_gnt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t q [NC][$];
  bit    pkt_act [NC];
  bit    gerr;
  int    checks = 0;
  int    failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NC; k++) begin
      q[k].delete();
      pkt_act[k] = 1'b0;
    end
    gerr = 1'b0;
  endtask

  // Compare the DUT's current outputs against what the model says for these inputs,
  // then (outside reset) advance the model to the state after the coming edge.
  task automatic check_and_step(input bit advance);
    logic [NC-1:0] e_ready, e_req, e_lock;
    logic          e_valid, e_last;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_src;
    int            ones, idx;
    ones = $countones(i_gnt);
    idx  = 0;
    for (int k = 0; k < NC; k++) begin
      if (i_gnt[k]) idx = k;
      e_ready[k] = (q[k].size() < FD);
      e_req[k]   = (q[k].size() > 0);
`ifdef ARB_INGRESS_LOCK_EN
      e_lock[k]  = pkt_act[k] || (q[k].size() > 0 && !q[k][0].l);
`else
      e_lock[k]  = 1'b0;
`endif
    end
    e_valid = (ones == 1) && (q[idx].size() > 0);
    e_data  = e_valid ? q[idx][0].d : '0;
    e_last  = e_valid ? q[idx][0].l : 1'b0;
    e_src   = e_valid ? SW'(idx) : '0;

    check_val("s_ready",   64'(s_ready),   64'(e_ready));
    check_val("o_req",     64'(o_req),     64'(e_req));
    check_val("o_lock",    64'(o_lock),    64'(e_lock));
    check_val("m_valid",   64'(m_valid),   64'(e_valid));
    check_val("m_data",    64'(m_data),    64'(e_data));
    check_val("m_last",    64'(m_last),    64'(e_last));
    check_val("m_src",     64'(m_src),     64'(e_src));
    check_val("o_gnt_err", 64'(o_gnt_err), 64'(gerr));

    if (advance) begin
      if (e_valid && m_ready) begin
        pkt_act[idx] = !q[idx][0].l;
        void'(q[idx].pop_front());
      end
      for (int k = 0; k < NC; k++) begin
        if (s_valid[k] && e_ready[k])
          q[k].push_back('{d: s_data[k*DW +: DW], l: s_last[k]});
      end
      if (ones > 1) gerr = 1'b1;
    end
  endtask

  int rst_cnt;
  int cur;
  int vprob, rprob;
  bit multi_ok;

  initial begin
    rst = 1'b1; s_valid = '0; s_data = '0; s_last = '0; i_gnt = '0; m_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 check_and_step(1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cur = 0; rst_cnt = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      case ((cyc / 500) % 4)
        0:       begin vprob = 90; rprob = 20; multi_ok = 1'b0; end
        1:       begin vprob = 50; rprob = 50; multi_ok = 1'b0; end
        2:       begin vprob = 20; rprob = 90; multi_ok = 1'b0; end
        default: begin vprob = 60; rprob = 60; multi_ok = 1'b1; end
      endcase
      if (cyc % 700 == 350) rst_cnt = 3;
      if (rst_cnt > 0) begin
        rst = 1'b1;
        rst_cnt--;
        model_clear();
      end else begin
        rst = 1'b0;
      end

      for (int k = 0; k < NC; k++) begin
        s_valid[k] = ($urandom_range(0, 99) < vprob);
        s_last[k]  = ($urandom_range(0, 2) == 0);
        s_data[k*DW +: DW] = $urandom;
      end
      m_ready = ($urandom_range(0, 99) < rprob);

      begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 8) begin
          i_gnt = '0;
        end else if (r < 11 && multi_ok) begin
          int a, b;
          a = $urandom_range(0, NC-1);
          b = (a + $urandom_range(1, NC-1)) % NC;
          i_gnt = '0;
          i_gnt[a] = 1'b1;
          i_gnt[b] = 1'b1;
        end else begin
          if ($urandom_range(0, 99) < 35) cur = $urandom_range(0, NC-1);
          i_gnt = '0;
          i_gnt[cur] = 1'b1;
        end
      end

      #1 check_and_step(!rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_ingress_queue.md
ARB_INGRESS_QUEUE -- requirements
Module: arb_ingress_queue

Interface
REQ-001 Parameter NUM_CLIENTS, default 4: number of client ports; SHALL be >=2.
REQ-002 Parameter DATA_WIDTH, default 32: beat payload width.
REQ-003 Parameter FIFO_DEPTH, default 4: per-client queue depth in beats; SHALL be a power of 2, >=2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_valid  input  NUM_CLIENTS  per-client beat valid.
REQ-007 s_ready  output  NUM_CLIENTS  per-client beat accept.
REQ-008 s_data  input  NUM_CLIENTS*DATA_WIDTH  packed payloads, client 0 in LSBs.
REQ-009 s_last  input  NUM_CLIENTS  per-client end-of-packet flag.
REQ-010 o_req  output  NUM_CLIENTS  request vector to the WRR arbiter's i_req.
REQ-011 o_lock  output  NUM_CLIENTS  lock vector to the WRR arbiter's i_lock.
REQ-012 i_gnt  input  NUM_CLIENTS  one-hot grant from the arbiter's o_gnt.
REQ-013 m_valid  output  1  merged output beat valid.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 m_data  output  DATA_WIDTH  merged output payload.
REQ-016 m_last  output  1  merged output end-of-packet.
REQ-017 m_src  output  $clog2(NUM_CLIENTS)  index of client owning the current beat.
REQ-018 o_gnt_err  output  1  sticky flag: i_gnt seen non-one-hot while nonzero.

Function
REQ-019 Each client k SHALL own an independent FIFO of FIFO_DEPTH entries {data,last}, with read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection.
REQ-020 s_ready[k] SHALL be !full[k]; push occurs when s_valid[k] && s_ready[k]; no full-bypass: a full FIFO refuses push even while popping in the same cycle.
REQ-021 o_req[k] SHALL be !empty[k], combinational from registered pointers.
REQ-022 Per client, pkt_active[k] SHALL be set when a beat with last=0 pops and cleared when a beat with last=1 pops.
REQ-023 o_lock[k] SHALL be pkt_active[k] || (!empty[k] && head_last[k]==0), so the arbiter keeps grant until the last beat leaves.
REQ-024 m_valid SHALL be 1 iff i_gnt is one-hot with bit k set and !empty[k]; m_data/m_last/m_src SHALL then show FIFO k's head and k; otherwise m_data, m_last, m_src SHALL be 0.
REQ-025 Pop of FIFO k occurs when m_valid && m_ready && i_gnt[k]; latency from push to earliest pop is 1 cycle (entry visible on the edge after write).
REQ-026 Simultaneous push and pop on the same non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-027 Pointers SHALL wrap modulo 2*FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH nor underflows.
REQ-028 i_gnt == 0 SHALL give m_valid=0 and no pop; i_gnt with >1 bit set SHALL give m_valid=0, no pop, and set o_gnt_err on the next edge.
REQ-029 o_gnt_err SHALL stay set until reset.
REQ-030 If FIFO k empties mid-packet, o_req[k] drops, pkt_active[k] stays set; remaining beats resume the packet when re-granted.

Reset
REQ-031 While rst=1, all pointers, pkt_active and o_gnt_err SHALL clear asynchronously: s_ready all 1, o_req 0, o_lock 0, m_valid 0, m_data 0, m_last 0, m_src 0, o_gnt_err 0.
REQ-032 Reset asserted mid-packet SHALL discard all queued beats; no beat pops on the cycle reset deasserts unless pushed after deassertion.

Configuration
REQ-033 Macro ARB_INGRESS_LOCK_EN: when defined, o_lock follows REQ-023 and pkt_active logic is built; when undefined, o_lock SHALL be constant 0, pkt_active is absent, and packets may interleave beat-by-beat at arbiter weight boundaries.

Verification
REQ-034 Reset: rst=1 for 3 cycles mid-traffic -> s_ready=4'b1111, o_req=0, m_valid=0, o_gnt_err=0 while asserted.
REQ-035 Fill client 2 with 5 beats, m_ready=0 -> s_ready[2]=0 after 4 accepts, 5th beat held; one pop with i_gnt=4'b0100 -> s_ready[2]=1 next cycle.
REQ-036 Client 0 pushes 3-beat packet (last on beat 3), LOCK_EN defined -> o_lock[0]=1 until beat 3 pops, then 0; m_data order matches push order, m_src=0.
REQ-037 i_gnt=4'b0011 with clients 0,1 non-empty -> m_valid=0, no pops, o_gnt_err=1 next edge and remains 1.
REQ-038 Concurrent push/pop on client 1 at occupancy 2 for 10 cycles -> occupancy stays 2, pointers wrap, data in order.
REQ-039 Connected to arbiter_wrr_lock with weights all 1, clients 0-3 each sending 2-beat packets -> no interleaving within a packet at m_* when LOCK_EN defined.
